// File: rtl/lcd_pcf8574_writer_if.sv
// lcd_pcf8574_writer_if: request/status and I2C byte-writer handshake bundle
// Ports: requester side in_valid/in_ready/in_data/in_rs/in_nib/backlight, status busy/done/err,
// byte-writer side bw_start/bw_data/bw_first/bw_last out, bw_done/bw_nack back.
interface lcd_pcf8574_writer_if;
  logic       in_valid, in_ready, in_rs, in_nib, backlight;
  logic [7:0] in_data;
  logic       busy, done, err;
  logic       bw_start, bw_first, bw_last, bw_done, bw_nack;
  logic [7:0] bw_data;
  modport master (
    output in_valid, in_data, in_rs, in_nib, backlight, bw_done, bw_nack,
    input  in_ready, busy, done, err, bw_start, bw_data, bw_first, bw_last
  );
  modport slave (
    input  in_valid, in_data, in_rs, in_nib, backlight, bw_done, bw_nack,
    output in_ready, busy, done, err, bw_start, bw_data, bw_first, bw_last
  );
endinterface

// File: rtl/lcd_pcf8574_writer.sv
// lcd_pcf8574_writer: sends one HD44780 4-bit byte through a PCF8574 as a single I2C transaction
// Ports: clk, rst (sync, active high); bus = slave side of lcd_pcf8574_writer_if
// (valid/ready request in, busy/done/err status out, start/done handshake to an I2C byte-writer).
module lcd_pcf8574_writer #(
  parameter logic [6:0] I2C_ADDR      = 7'h27,
  parameter int         EN_HOLD_CYC   = 25,
  parameter int         EXEC_CYC      = 40,
  parameter int         LONG_EXEC_CYC = 1600,
  parameter int         CNT_W         = 21
) (
  input logic                 clk,
  input logic                 rst,
  lcd_pcf8574_writer_if.slave bus
);
  typedef enum logic [3:0] {IDLE, ADDR, HI_EN, HOLD1, HI_NE, LO_EN, HOLD2, LO_NE, EXEC, DONE} state_t;
  state_t           state_q, state_d;
  logic [7:0]       d_q, d_d;
  logic             rs_q, rs_d, nib_q, nib_d, bl_q, bl_d, out_q, out_d, err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, dwell_end;
  logic             byte_st, start, ack, dwell, fin, en, long_ex;
  logic [3:0]       nibble;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      d_q     <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      bl_q    <= 1'b0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      rs_q    <= rs_d;
      nib_q   <= nib_d;
      bl_q    <= bl_d;
      out_q   <= out_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    rs_d    = rs_q;
    nib_d   = nib_q;
    bl_d    = bl_q;
    out_d   = out_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    byte_st = state_q inside {ADDR, HI_EN, HI_NE, LO_EN, LO_NE};
    // out_q marks the byte issued in this state as outstanding; bw_done is only honoured then
    start   = byte_st && !out_q;
    ack     = byte_st && out_q && bus.bw_done;
    nibble  = (state_q == LO_EN || state_q == LO_NE) ? d_q[3:0] : d_q[7:4];
    en      = state_q == HI_EN || state_q == LO_EN;
    // clear/home commands need the long execute time regardless of nibble mode
    long_ex = !rs_q && d_q inside {8'h01, 8'h02, 8'h03};
    dwell   = state_q inside {HOLD1, HOLD2, EXEC};
    dwell_end = state_q != EXEC ? CNT_W'(EN_HOLD_CYC - 1) :
                long_ex ? CNT_W'(LONG_EXEC_CYC - 1) : CNT_W'(EXEC_CYC - 1);
    fin     = dwell && cnt_q == dwell_end;
    bus.in_ready = state_q == IDLE;
    bus.busy     = state_q != IDLE;
    bus.done     = state_q == DONE;
    bus.err      = state_q == DONE && err_q;
    bus.bw_start = start;
    bus.bw_data  = !start ? 8'h00 : state_q == ADDR ? {I2C_ADDR, 1'b0} : {nibble, bl_q, en, 1'b0, rs_q};
    bus.bw_first = start && state_q == ADDR;
    bus.bw_last  = start && (state_q == LO_NE || (state_q == HI_NE && nib_q));
    if (start) out_d = 1'b1;
    if (ack) out_d = 1'b0;
    if (dwell) cnt_d = fin ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: if (bus.in_valid) begin
        state_d = ADDR;
        d_d     = bus.in_data;
        rs_d    = bus.in_rs;
        nib_d   = bus.in_nib;
        bl_d    = bus.backlight;
        err_d   = 1'b0;
      end
      ADDR:    if (ack) state_d = HI_EN;
      HI_EN:   if (ack) state_d = HOLD1;
      HOLD1:   if (fin) state_d = HI_NE;
      HI_NE:   if (ack) state_d = nib_q ? EXEC : LO_EN;
      LO_EN:   if (ack) state_d = HOLD2;
      HOLD2:   if (fin) state_d = LO_NE;
      LO_NE:   if (ack) state_d = EXEC;
      EXEC:    if (fin) state_d = DONE;
      default: state_d = IDLE;
    endcase
    // a NACK abandons the rest of the transaction; the byte-writer already handles STOP
    if (ack && bus.bw_nack) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
  end
endmodule

// File: tb/tb_lcd_pcf8574_writer.sv
// tb_lcd_pcf8574_writer: randomized and directed bench with a transaction-level timing model
module tb_lcd_pcf8574_writer;
  localparam int H = 4, E = 6, L = 50;
  localparam logic [6:0] ADR = 7'h27;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int fix_dly = 3, nack_pct = 0;
  logic nack_once = 1'b0, stray_en = 1'b0;
  always #5 clk = ~clk;
  lcd_pcf8574_writer_if bus();
  lcd_pcf8574_writer #(.I2C_ADDR(ADR), .EN_HOLD_CYC(H), .EXEC_CYC(E), .LONG_EXEC_CYC(L), .CNT_W(8))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  // model: list of bytes still to send, and the cycle at which the next start or done is due
  int cyc = 0, acc_n = 0, done_n = 0, err_n = 0, done_cyc = 0;
  int m_kind = 0, m_due = 0;
  logic m_busy = 1'b0, m_err = 1'b0, m_long = 1'b0, m_first = 1'b0;
  logic [7:0] m_q[$];
  logic m_h[$];
  logic [9:0] st_log[$];
  int st_cyc[$], bd_cyc[$];
  always @(negedge clk) begin : model
    logic xs, xd, idle, hold;
    int hi, lo, b, r, d;
    cyc++;
    idle = !m_busy;
    if (!rst && m_kind == 2 && bus.bw_done) begin
      bd_cyc.push_back(cyc);
      if (bus.bw_nack) begin
        m_kind = 3; m_due = cyc + 1; m_err = 1'b1;
      end else begin
        void'(m_q.pop_front());
        hold = m_h.pop_front();
        if (m_q.size() != 0) begin m_kind = 1; m_due = cyc + 1 + (hold ? H : 0); end
        else begin m_kind = 3; m_due = cyc + 1 + (m_long ? L : E); end
      end
    end
    xs = m_kind == 1 && m_due == cyc;
    xd = m_kind == 3 && m_due == cyc;
    chk("in_ready", bus.in_ready, idle);
    chk("busy", bus.busy, !idle);
    chk("bw_start", bus.bw_start, xs);
    chk("done", bus.done, xd);
    chk("err", bus.err, xd && m_err);
    if (xs) begin
      chk("bw_data", bus.bw_data, m_q[0]);
      chk("bw_first", bus.bw_first, m_first);
      chk("bw_last", bus.bw_last, m_q.size() == 1);
      st_log.push_back({bus.bw_first, bus.bw_last, bus.bw_data});
      st_cyc.push_back(cyc);
      m_first = 1'b0; m_kind = 2;
    end
    if (xd) begin
      done_n++; if (bus.err) err_n++;
      done_cyc = cyc; m_busy = 1'b0; m_kind = 0;
    end
    if (rst) begin
      m_busy = 1'b0; m_kind = 0; m_q.delete(); m_h.delete();
    end else if (idle && bus.in_valid) begin
      acc_n++;
      d = int'(bus.in_data); hi = d / 16; lo = d % 16;
      b = bus.backlight ? 8 : 0; r = bus.in_rs ? 1 : 0;
      m_q.delete(); m_h.delete();
      m_q.push_back(8'(int'(ADR) * 2)); m_h.push_back(1'b0);
      m_q.push_back(8'(hi * 16 + b + 4 + r)); m_h.push_back(1'b1);
      m_q.push_back(8'(hi * 16 + b + r)); m_h.push_back(1'b0);
      if (!bus.in_nib) begin
        m_q.push_back(8'(lo * 16 + b + 4 + r)); m_h.push_back(1'b1);
        m_q.push_back(8'(lo * 16 + b + r)); m_h.push_back(1'b0);
      end
      m_long = r == 0 && d >= 1 && d <= 3;
      m_kind = 1; m_due = cyc + 1; m_busy = 1'b1; m_err = 1'b0; m_first = 1'b1;
    end
  end
  // I2C byte-writer stand-in
  initial begin
    int pend, dly;
    logic nk;
    pend = 0; dly = 0; nk = 1'b0;
    bus.bw_done = 1'b0; bus.bw_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend = 0;
      else if (bus.bw_start) begin
        pend = 1;
        dly = fix_dly > 0 ? fix_dly : int'($urandom_range(1, 4));
        nk = nack_once || ($urandom_range(0, 99) < nack_pct);
        nack_once = 1'b0;
      end
      @(posedge clk); #1;
      bus.bw_done = 1'b0; bus.bw_nack = 1'b0;
      if (pend != 0) begin
        dly--;
        if (dly == 0) begin bus.bw_done = 1'b1; bus.bw_nack = nk; pend = 0; end
      end else if (stray_en && $urandom_range(0, 5) == 0) begin
        bus.bw_done = 1'b1; bus.bw_nack = 1'($urandom_range(0, 1));
      end
    end
  end
  task automatic send(input logic [7:0] d, input logic rs, input logic nib, input logic bl);
    int a0, t;
    st_log.delete(); st_cyc.delete(); bd_cyc.delete();
    a0 = acc_n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_rs = rs; bus.in_nib = nib; bus.backlight = bl;
    t = 0;
    while (acc_n == a0 && t < 50) begin @(posedge clk); t++; end
    #1;
    bus.in_valid = 1'b0; bus.in_data = 8'($urandom); bus.in_rs = 1'($urandom);
    bus.in_nib = 1'($urandom); bus.backlight = 1'($urandom);
  endtask
  task automatic req(input logic [7:0] d, input logic rs, input logic nib, input logic bl);
    int n0, t;
    n0 = done_n;
    send(d, rs, nib, bl);
    t = 0;
    while (done_n == n0 && t < 3000) begin @(posedge clk); t++; end
    chk("req_done", done_n - n0, 1);
    #1;
  endtask
  task automatic chk_log(input string name, input int n, input logic [9:0] e0, e1, e2, e3, e4);
    logic [9:0] e[5];
    e = '{e0, e1, e2, e3, e4};
    chk({name, "_count"}, st_log.size(), n);
    for (int i = 0; i < n && i < st_log.size(); i++) chk(name, st_log[i], e[i]);
  endtask
  initial begin
    int n0, a0, e0, t;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_rs = 1'b0; bus.in_nib = 1'b0; bus.backlight = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", bus.in_ready, 1);
    chk("rst_start", bus.bw_start, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    req(8'h28, 1'b0, 1'b0, 1'b1);
    chk_log("cmd28", 5, 10'h24E, 10'h02C, 10'h028, 10'h08C, 10'h188);
    chk("addr_to_hi", st_cyc[1] - bd_cyc[0], 1);
    chk("hold_gap", st_cyc[2] - bd_cyc[1], H + 1);
    chk("exec_gap", done_cyc - bd_cyc[4], E + 1);
    e0 = err_n;
    req(8'h41, 1'b1, 1'b0, 1'b1);
    chk_log("data41", 5, 10'h24E, 10'h04D, 10'h049, 10'h01D, 10'h119);
    chk("data41_err", err_n - e0, 0);
    req(8'h30, 1'b0, 1'b1, 1'b1);
    chk_log("nib30", 3, 10'h24E, 10'h03C, 10'h138, 10'h000, 10'h000);
    chk("nib_exec_gap", done_cyc - bd_cyc[2], E + 1);
    req(8'h28, 1'b0, 1'b0, 1'b0);
    chk_log("cmd28_nobl", 5, 10'h24E, 10'h024, 10'h020, 10'h084, 10'h180);
    req(8'h01, 1'b0, 1'b0, 1'b1);
    chk("clear_long", done_cyc - bd_cyc[4], L + 1);
    req(8'h01, 1'b1, 1'b0, 1'b1);
    chk("data01_short", done_cyc - bd_cyc[4], E + 1);
    e0 = err_n;
    nack_once = 1'b1;
    req(8'h55, 1'b1, 1'b0, 1'b1);
    chk("nack_starts", st_log.size(), 1);
    chk("nack_err", err_n - e0, 1);
    chk("nack_done_gap", done_cyc - bd_cyc[0], 1);
    chk("nack_ready", bus.in_ready, 1);
    e0 = err_n;
    req(8'h0C, 1'b0, 1'b0, 1'b1);
    chk_log("after_nack", 5, 10'h24E, 10'h00C, 10'h008, 10'h0CC, 10'h1C8);
    chk("after_nack_err", err_n - e0, 0);
    fix_dly = 2;
    n0 = done_n;
    send(8'h28, 1'b0, 1'b0, 1'b1);
    t = 0;
    while (bd_cyc.size() < 4 && t < 500) begin @(posedge clk); t++; end
    chk("hold2_reach", bd_cyc.size(), 4);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold2_starts", st_log.size(), 4);
    chk("rst_hold2_done", done_n - n0, 0);
    chk("rst_hold2_ready", bus.in_ready, 1);
    fix_dly = 1;
    n0 = done_n; a0 = acc_n;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_data = 8'h48; bus.in_rs = 1'b1; bus.in_nib = 1'b0; bus.backlight = 1'b1;
    t = 0;
    while (done_n - n0 < 3 && t < 2000) begin @(posedge clk); t++; end
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    chk("stream_accepts", acc_n - a0, 3);
    chk("stream_dones", done_n - n0, 3);
    fix_dly = 0; nack_pct = 10; stray_en = 1'b1;
    n0 = done_n;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 299) == 0;
      bus.in_valid = $urandom_range(0, 3) != 0;
      bus.in_data = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 4)) : 8'($urandom);
      bus.in_rs = 1'($urandom); bus.in_nib = $urandom_range(0, 3) == 0; bus.backlight = 1'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; stray_en = 1'b0;
    repeat (5) @(posedge clk);
    chk("random_progress", done_n - n0 > 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
